// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side burst reader.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        BURST = 2'd2
    } rd_state_t;

    localparam int SKID_DEPTH = 2;
    localparam int STAT_WIDTH = 16;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry registered valid/ready buffer (SKID_DEPTH entries). The output
// register presents the stream; the hold register catches the one word that
// arrives while the output is stalled. s_ready comes straight from a flop, so
// nothing on the downstream side reaches s_ready combinationally.
module skid_buffer
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             occupied
);

    logic             hold_valid;
    logic [WIDTH-1:0] hold_data;
    logic             push;

    assign s_ready  = !hold_valid;
    assign push     = s_valid && s_ready;
    assign occupied = m_valid || hold_valid;

    // Output register refills from the hold slot first, then from the input;
    // while the output is stalled an incoming word parks in the hold slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (!m_valid || m_ready) begin
            if (hold_valid) begin
                m_data     <= hold_data;
                m_valid    <= 1'b1;
                hold_valid <= 1'b0;
            end else if (push) begin
                m_data  <= s_data;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (push) begin
            hold_data  <= s_data;
            hold_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a first-word-fall-through FIFO in bursts onto a valid/ready stream
// with a last flag on the final word of each burst.
// Optional statistics counters: define FIFO_BURST_READER_STATS_EN.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | FIFO empty, timer held clear
// ARM   | words queued; timer runs until threshold, flush or timeout
// BURST | popping a fixed number of words into the skid buffer
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DWIDTH         = 20,
    parameter int COUNT_WIDTH    = 7,
    parameter int BURST_LEN      = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DWIDTH-1:0]      fifo_dout,
    input  logic                   fifo_empty,
    input  logic [COUNT_WIDTH-1:0] fifo_data_count,
    output logic                   fifo_rd_en,
    input  logic                   flush,
    output logic [DWIDTH-1:0]      m_data,
    output logic                   m_valid,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic                   busy
`ifdef FIFO_BURST_READER_STATS_EN
   ,output logic [STAT_WIDTH-1:0]  burst_cnt,
    output logic [STAT_WIDTH-1:0]  timeout_cnt
`endif
);

    localparam int                     TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_MAX   = TIMER_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] BURST_LEN_C = COUNT_WIDTH'(BURST_LEN);
    localparam logic [COUNT_WIDTH-1:0] ONE_C       = COUNT_WIDTH'(1);

    rd_state_t               state, state_nxt;
    logic [TIMER_WIDTH-1:0]  timer, timer_nxt;
    logic [COUNT_WIDTH-1:0]  remaining, remaining_nxt;
    logic                    threshold_met;
    logic                    timer_expired;
    logic                    skid_ready;
    logic                    skid_occupied;
    logic [DWIDTH:0]         skid_in;
    logic [DWIDTH:0]         skid_out;

    assign threshold_met = (fifo_data_count >= BURST_LEN_C);
    assign timer_expired = (timer == TIMER_MAX);
    assign skid_in       = {fifo_dout, (remaining == ONE_C)};

    // State, timer and remaining-word counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            remaining <= remaining_nxt;
        end
    end

    // Next-state, burst length capture and pop request.
    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        remaining_nxt = remaining;
        fifo_rd_en    = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (!fifo_empty) begin
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (!timer_expired) begin
                    timer_nxt = timer + TIMER_WIDTH'(1);
                end
                if (threshold_met) begin
                    state_nxt     = BURST;
                    remaining_nxt = BURST_LEN_C;
                end else if (flush || timer_expired) begin
                    // A zero-length burst would never terminate; fall back to
                    // IDLE if the occupancy reads empty at this point.
                    if (fifo_data_count != '0) begin
                        state_nxt     = BURST;
                        remaining_nxt = fifo_data_count;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            BURST: begin
                fifo_rd_en = skid_ready && !fifo_empty;
                if (fifo_rd_en) begin
                    remaining_nxt = remaining - ONE_C;
                    if (remaining == ONE_C) begin
                        timer_nxt = '0;
                        state_nxt = (fifo_data_count > ONE_C) ? ARM : IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    skid_buffer #(
        .WIDTH (DWIDTH + 1)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data   (skid_in),
        .s_valid  (fifo_rd_en),
        .s_ready  (skid_ready),
        .m_data   (skid_out),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .occupied (skid_occupied)
    );

    assign m_data = skid_out[DWIDTH:1];
    assign m_last = skid_out[0];
    assign busy   = (state != IDLE) || skid_occupied;

`ifdef FIFO_BURST_READER_STATS_EN
    logic timeout_entry;

    assign timeout_entry = (state == ARM) && !threshold_met && timer_expired
                           && (fifo_data_count != '0);

    // Completed-burst and timeout-burst counters; both wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt   <= '0;
            timeout_cnt <= '0;
        end else begin
            if (m_valid && m_ready && m_last) begin
                burst_cnt <= burst_cnt + STAT_WIDTH'(1);
            end
            if (timeout_entry) begin
                timeout_cnt <= timeout_cnt + STAT_WIDTH'(1);
            end
        end
    end
`endif

    // The reader is the only popper, so the FIFO cannot run dry mid-burst.
    a_no_empty_in_burst : assert property (
        @(posedge clk) disable iff (!rst_n) (state == BURST) |-> !fifo_empty
    ) else $error("fifo_burst_reader: FIFO went empty during a burst");

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: a queue-based FIFO model feeds the
// DUT, expected words and burst lengths are queued at write time and a
// negedge monitor checks every stream transfer against them.
module tb_fifo_burst_reader;
    localparam int DW = 20;
    localparam int CW = 7;
    localparam int BL = 16;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_empty = 1'b1;
    logic [CW-1:0] fifo_data_count = '0;
    logic          fifo_rd_en;
    logic          flush = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic          busy;
`ifdef FIFO_BURST_READER_STATS_EN
    logic [15:0]   burst_cnt;
    logic [15:0]   timeout_cnt;
`endif

    fifo_burst_reader #(
        .DWIDTH(DW), .COUNT_WIDTH(CW), .BURST_LEN(BL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_data_count(fifo_data_count), .fifo_rd_en(fifo_rd_en),
        .flush(flush),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .busy(busy)
`ifdef FIFO_BURST_READER_STATS_EN
       ,.burst_cnt(burst_cnt), .timeout_cnt(timeout_cnt)
`endif
    );

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    int            exp_len_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            pend_pop = 0;
    int            pops_total = 0;
    int            xfers = 0;
    int            rise_cyc = -1;
    int            rdy_mode = 1;
    int            exp_bursts = 0;
    int            exp_timeouts = 0;
    int            pos = 0;
    int            push_cyc = 0;

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // FIFO model: apply the pop the DUT committed at this edge, then refresh
    // the FWFT outputs once all same-cycle pushes have landed.
    initial forever begin
        @(posedge clk);
        #1;
        if (pend_pop) begin
            if (fq.size() > 0) void'(fq.pop_front());
            pend_pop = 0;
        end
        #1;
        fifo_empty      = (fq.size() == 0);
        fifo_dout       = (fq.size() == 0) ? '0 : fq[0];
        fifo_data_count = CW'(fq.size());
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            2:       m_ready = ~m_ready;
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor / scoreboard.
    initial begin
        bit            prev_stall = 0;
        bit            prev_valid = 0;
        logic [DW-1:0] prev_data = '0;
        bit            prev_last = 0;
        logic [DW-1:0] exp_word;
        bit            exp_last;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pos = 0;
                prev_stall = 0;
                prev_valid = 0;
                pend_pop = 0;
            end else begin
                if (fifo_rd_en) begin
                    check("rd_en_while_empty", fifo_empty, 0);
                    pops_total++;
                end
                pend_pop = fifo_rd_en;
                if (prev_stall) begin
                    check("stall_valid", m_valid, 1);
                    check("stall_data", m_data, prev_data);
                    check("stall_last", m_last, prev_last);
                end
                if (m_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
                if (m_valid && m_ready) begin
                    xfers++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got 0x%0h expected none", m_data);
                    end else begin
                        exp_word = exp_q.pop_front();
                        check("data", m_data, exp_word);
                        exp_last = (exp_len_q.size() > 0) && (pos + 1 == exp_len_q[0]);
                        check("last", m_last, exp_last);
                        pos++;
                        if (exp_len_q.size() > 0 && pos == exp_len_q[0]) begin
                            void'(exp_len_q.pop_front());
                            pos = 0;
                            exp_bursts++;
                        end
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_valid = m_valid;
                prev_data  = m_data;
                prev_last  = m_last;
            end
        end
    end

    task automatic push_words(int n, bit incr, int base);
        logic [DW-1:0] w;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            w = incr ? DW'(base + i) : DW'($urandom);
            fq.push_back(w);
            exp_q.push_back(w);
        end
        push_cyc = cyc;
    endtask

    // n words queued at once into an idle reader: full bursts while enough
    // are queued, then the remainder goes out on timeout.
    function automatic void expect_bursts(int n);
        int left = n;
        while (left >= BL) begin
            exp_len_q.push_back(BL);
            left -= BL;
        end
        if (left > 0) begin
            exp_len_q.push_back(left);
            exp_timeouts++;
        end
    endfunction

    task automatic wait_drain(string name, int limit);
        bit done = 0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk);
            if (fq.size() == 0 && exp_q.size() == 0 && !busy) done = 1;
        end
        check({name, "_drained"}, done, 1);
        check({name, "_bursts_left"}, exp_len_q.size(), 0);
`ifdef FIFO_BURST_READER_STATS_EN
        check({name, "_burst_cnt"}, burst_cnt, exp_bursts & 16'hffff);
        check({name, "_timeout_cnt"}, timeout_cnt, exp_timeouts & 16'hffff);
`endif
    endtask

    task automatic check_reset_outputs(string name);
        check({name, "_rd_en"}, fifo_rd_en, 0);
        check({name, "_m_valid"}, m_valid, 0);
        check({name, "_m_last"}, m_last, 0);
        check({name, "_m_data"}, m_data, 0);
        check({name, "_busy"}, busy, 0);
`ifdef FIFO_BURST_READER_STATS_EN
        check({name, "_burst_cnt"}, burst_cnt, 0);
        check({name, "_timeout_cnt"}, timeout_cnt, 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, x0, lost, n;
        rdy_mode = 1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Sixteen words one per cycle: first word arms, sixteenth triggers.
        for (int i = 1; i <= 16; i++) push_words(1, 1, i);
        exp_len_q.push_back(16);
        rise_cyc = -1;
        p0 = push_cyc;
        wait_drain("full16", 200);
        check("full16_latency", rise_cyc - p0, 2);

        // Five words, no flush: timeout burst.
        rise_cyc = -1;
        push_words(5, 0, 0);
        expect_bursts(5);
        p0 = push_cyc;
        wait_drain("timeout5", 200);
        check("timeout5_latency", rise_cyc - p0, TO + 3);

        // Three words, flush two cycles later.
        rise_cyc = -1;
        push_words(3, 0, 0);
        exp_len_q.push_back(3);
        p0 = push_cyc;
        @(posedge clk); #1;
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        wait_drain("flush3", 200);
        check("flush3_latency", rise_cyc - p0, 4);

        // Flush while idle does nothing.
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_flush_busy", busy, 0);
        check("idle_flush_valid", m_valid, 0);

        // Forty words with m_ready toggling every cycle.
        rdy_mode = 2;
        push_words(40, 1, 32'h100);
        expect_bursts(40);
        wait_drain("toggle40", 600);

        // Downstream fully stalled: only the two skid slots get filled.
        rdy_mode = 0;
        push_words(16, 0, 0);
        exp_len_q.push_back(16);
        p0 = pops_total;
        repeat (12) @(negedge clk);
        check("stall_pops", pops_total - p0, 2);
        check("stall_rd_en", fifo_rd_en, 0);
        rdy_mode = 1;
        wait_drain("stall16", 200);

        // Writer pushes during a burst: length stays 16, extras follow later.
        push_words(16, 1, 32'h200);
        exp_len_q.push_back(16);
        repeat (3) @(posedge clk);
        push_words(5, 1, 32'h300);
        exp_len_q.push_back(5);
        exp_timeouts++;
        wait_drain("midpush", 300);

        // Completely full FIFO with random back-pressure.
        rdy_mode = 3;
        push_words(127, 1, 32'h400);
        expect_bursts(127);
        wait_drain("full127", 1500);

        // Random batches.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 127);
            rdy_mode = $urandom_range(1, 3);
            push_words(n, 0, 0);
            expect_bursts(n);
            wait_drain("random", 1500);
        end

        // Reset after six transfers of a burst.
        rdy_mode = 1;
        push_words(16, 1, 32'h500);
        expect_bursts(16);
        x0 = xfers;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #3;
            if (xfers - x0 >= 6) break;
        end
        check("reset_after_xfers", xfers - x0, 6);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        lost = exp_q.size() - fq.size();
        check("midreset_discard_le2", (lost >= 0 && lost <= 2), 1);
        exp_q = fq;
        exp_len_q.delete();
        exp_bursts = 0;
        exp_timeouts = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        expect_bursts(fq.size());
        wait_drain("post_reset", 300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
